ahb_arbiter: RTL and testbench
==============================

Name: ahb_arbiter

Overview:
- AHB bus arbiter for one layer of the bus matrix: one dummy master (index 0) plus three real masters (indices 1-3).
- Drives the HGRANT input of ahb_dummy_master and of each real master.
- Drives HMASTER and HMASTLOCK to the address/control mux and to the slaves.
- Uses fixed priority and honours fixed-length bursts, locked sequences and SPLIT masking. It parks on a default master, or on the dummy master when no other choice is legal.

Parameters:
- DEFAULT_MASTER, 1: master granted when nobody requests. Legal values 1-3.

Ports:
- HCLK  input  1  bus clock.
- HRESETn  input  1  asynchronous active-low reset.
- HBUSREQ  input  4  bus requests. Bit 0 is ignored; the dummy master never requests.
- HLOCK  input  4  lock requests, one per master. Bit 0 is always low.
- HTRANS  input  2  transfer type of the current address-phase owner.
- HBURST  input  3  burst type of the current address-phase owner.
- HREADY  input  1  bus ready.
- HRESP  input  2  slave response.
- HSPLIT  input  4  split-resume bits, ORed from all slaves.
- HGRANT  output  4  one-hot grant.
- HMASTER  output  2  index of the master owning the address phase.
- HMASTLOCK  output  1  current address-phase transfer is locked.

Behaviour:
- Encodings:
  - HTRANS: IDLE 00, BUSY 01, NONSEQ 10, SEQ 11.
  - HRESP: OKAY 00, ERROR 01, RETRY 10, SPLIT 11.
  - HBURST: SINGLE 000, INCR 001, WRAP4 010, INCR4 011, WRAP8 100, INCR8 101, WRAP16 110, INCR16 111.
- Reset (async, while HRESETn low):
  - HGRANT = one-hot(DEFAULT_MASTER), HMASTER = DEFAULT_MASTER.
  - HMASTLOCK = 0, split mask = 0, beat counter = 0, locked-split flag = 0.
- Registers: all update only on HCLK rising edge.
- Grant/ownership latency:
  - HGRANT is registered.
  - A new grant takes effect on HCLK only when HREADY=1.
  - HMASTER takes the value of the granted index on the next HREADY=1 edge after HGRANT changed (address-phase handover).
  - HMASTLOCK is loaded with HLOCK[granted] at the same handover edge.
- Beat counter (4 bits):
  - Loads length-1 on HTRANS=NONSEQ with HREADY=1 for fixed bursts: 3, 7 or 15.
  - SINGLE and INCR load 0.
  - Decrements on SEQ with HREADY=1 while nonzero.
  - BUSY holds it.
  - Re-arbitration is blocked while the counter is nonzero.
  - At counter=1 with SEQ and HREADY=1, arbitration is permitted in that same cycle, so the new grant overlaps the last beat.
  - An ERROR or RETRY response clears the counter.
- Split mask (4 bits, bit 0 always 0):
  - Bit HMASTER is set in the first cycle of a SPLIT response (HRESP=11, HREADY=0).
  - Bit n is cleared when HSPLIT[n]=1.
  - Set and clear of the same bit in the same cycle: clear wins.
  - A masked master's HBUSREQ is treated as 0.
- Locked SPLIT:
  - If HMASTLOCK=1 when a SPLIT is received, set the locked-split flag and remember the master index.
  - While the flag is set, grant only master 0.
  - The flag clears when that master's mask bit clears.
- Next-grant selection, evaluated when arbitration is permitted, in priority order:
  - (a) Locked-split flag set -> master 0.
  - (b) Current owner has HLOCK=1 and is unmasked -> keep the current owner.
  - (c) Highest-priority unmasked requester, where 1 is highest and 3 is lowest.
  - (d) No requester and DEFAULT_MASTER unmasked -> DEFAULT_MASTER.
  - (e) Otherwise, including when all real masters are masked -> master 0.
- Undefined-state check: HGRANT must always be one-hot. Any illegal state returns to the reset values on the next edge.
- HREADY=0 freezes HGRANT, HMASTER, HMASTLOCK and the beat counter. The split mask still updates.

Test Plan:
- Reset, then release with no requests:
  - Required: HGRANT=0010, HMASTER=1, HMASTLOCK=0.
  - HGRANT stays 0010 for 10 cycles.
- Requests from M2 and M3 while M1 owns the bus:
  - Drive HBUSREQ=1100.
  - Required: HGRANT=0100 one cycle later and HMASTER=2 one HREADY edge after that.
  - Drop M2's request; required: HGRANT=1000.
- M2 granted with INCR4 (NONSEQ + 3 SEQ), M1 requesting throughout:
  - Required: HGRANT stays 0100 until the cycle of the 4th beat, then becomes 0010.
  - Repeat with 2 wait states on beat 2; required: the handover is delayed by exactly 2 cycles.
- M1 gets SPLIT (HRESP=11 for 2 cycles, HREADY 0 then 1), no other requests:
  - Required: mask=0010 and HGRANT=0001.
  - Pulse HSPLIT=0010; required: mask clears and HGRANT returns to 0010.
- M3 locked (HLOCK=1000) and SPLIT while M1 and M2 are requesting:
  - Required: HGRANT=0001 until HSPLIT[3]; M1 and M2 are not granted meanwhile.
  - After HSPLIT[3], M3 is regranted if it still holds HLOCK.
- Assert HRESETn low mid-INCR8 (beat 3):
  - Required: outputs return immediately (asynchronously) to the reset values and the counter reads 0.
  - After release, arbitration runs normally.

Source files
------------

// File: rtl/ahb_arbiter.sv
// AHB arbiter for one bus-matrix layer: dummy master 0 plus real masters 1-3.
// The grant is registered. Fixed priority is 1 > 2 > 3. Fixed-length bursts,
// locked sequences and SPLIT masking are honoured. With no requester the
// arbiter parks on DEFAULT_MASTER, or on the dummy master when that is masked.
module ahb_arbiter #(
    parameter int DEFAULT_MASTER = 1
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic [3:0] HBUSREQ,
    input  logic [3:0] HLOCK,
    input  logic [1:0] HTRANS,
    input  logic [2:0] HBURST,
    input  logic       HREADY,
    input  logic [1:0] HRESP,
    input  logic [3:0] HSPLIT,
    output logic [3:0] HGRANT,
    output logic [1:0] HMASTER,
    output logic       HMASTLOCK
);

    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [1:0] RSP_OKAY  = 2'b00;
    localparam logic [1:0] RSP_SPLIT = 2'b11;

    localparam logic [1:0] DEF_IDX   = 2'(DEFAULT_MASTER);
    localparam logic [3:0] DEF_GRANT = 4'b0001 << DEFAULT_MASTER;

    logic [3:0] hgrant_reg, hgrant_next;
    logic [1:0] hmaster_reg, hmaster_next;
    logic       hmastlock_reg, hmastlock_next;
    logic [3:0] beat_cnt_reg, beat_cnt_next;
    logic [3:0] split_mask_reg, split_mask_next;
    logic       lock_split_reg, lock_split_next;
    logic [1:0] lock_split_idx_reg, lock_split_idx_next;

    logic [3:0] split_mask_calc;
    logic [3:0] eff_req;
    logic [3:0] sel_grant;
    logic [1:0] grant_idx;
    logic       split_set;
    logic       fixed_burst;
    logic       arb_permit;
    logic       state_ok;
    logic       unused_bits;

    // Bit 0 of the request and split-resume buses belongs to the dummy master
    // and carries no information.
    assign unused_bits = ^{HBUSREQ[0], HSPLIT[0]};

    // First cycle of a two-cycle SPLIT response.
    assign split_set = (HRESP == RSP_SPLIT) && !HREADY;

    // Index of the master currently holding the grant (grant is one-hot).
    assign grant_idx = {hgrant_reg[3] | hgrant_reg[2], hgrant_reg[3] | hgrant_reg[1]};

    // Per-master split mask update and masked request vector.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_master
            if (gi == 0) begin : g_dummy
                assign split_mask_calc[gi] = 1'b0;
                assign eff_req[gi]         = 1'b0;
            end else begin : g_real
                // A resume pulse on the same edge as a new split wins.
                assign split_mask_calc[gi] = (split_mask_reg[gi] |
                                              (split_set && (hmaster_reg == 2'(gi))))
                                             & ~HSPLIT[gi];
                assign eff_req[gi]         = HBUSREQ[gi] & ~split_mask_reg[gi];
            end
        end
    endgenerate

    // Fixed-length bursts (WRAP4..INCR16) have a nonzero HBURST[2:1].
    assign fixed_burst = |HBURST[2:1];

    // Arbitration is allowed between bursts, never on the NONSEQ that opens a
    // fixed burst, and on the last beat so the new grant overlaps it.
    assign arb_permit = HREADY &&
                        (((beat_cnt_reg == 4'd0) && !((HTRANS == TR_NONSEQ) && fixed_burst)) ||
                         ((beat_cnt_reg == 4'd1) && (HTRANS == TR_SEQ)));

    // Any non-one-hot grant or impossible mask/flag combination is illegal.
    assign state_ok = (hgrant_reg != 4'd0) &&
                      ((hgrant_reg & (hgrant_reg - 4'd1)) == 4'd0) &&
                      !split_mask_reg[0] &&
                      !(lock_split_reg && (lock_split_idx_reg == 2'd0));

    // Next-grant priority selection.
    always_comb begin
        sel_grant = 4'b0001;
        if (lock_split_reg) begin
            // Parked on the dummy master; a locked master whose split resumes
            // while still holding HLOCK gets the bus straight back.
            if (HSPLIT[lock_split_idx_reg] && HLOCK[lock_split_idx_reg])
                sel_grant = 4'b0001 << lock_split_idx_reg;
        end else if (HLOCK[grant_idx] && !split_mask_reg[grant_idx]) begin
            sel_grant = hgrant_reg;
        end else if (eff_req[1]) begin
            sel_grant = 4'b0010;
        end else if (eff_req[2]) begin
            sel_grant = 4'b0100;
        end else if (eff_req[3]) begin
            sel_grant = 4'b1000;
        end else if (!split_mask_reg[DEF_IDX]) begin
            sel_grant = DEF_GRANT;
        end
    end

    // Next-state for grant, ownership, beat counter, mask and locked-split flag.
    always_comb begin
        hgrant_next         = hgrant_reg;
        hmaster_next        = hmaster_reg;
        hmastlock_next      = hmastlock_reg;
        beat_cnt_next       = beat_cnt_reg;
        split_mask_next     = split_mask_calc;
        lock_split_next     = lock_split_reg;
        lock_split_idx_next = lock_split_idx_reg;

        if (arb_permit)
            hgrant_next = sel_grant;

        if (HREADY) begin
            // Address-phase handover to whoever held the grant this cycle.
            hmaster_next   = grant_idx;
            hmastlock_next = HLOCK[grant_idx];
        end

        // Any non-OKAY response ends the burst; a split owner is masked, so
        // holding the count would only keep the grant on a masked master.
        if (HRESP != RSP_OKAY) begin
            beat_cnt_next = 4'd0;
        end else if (HREADY) begin
            if (HTRANS == TR_NONSEQ) begin
                case (HBURST)
                    3'b010, 3'b011: beat_cnt_next = 4'd3;
                    3'b100, 3'b101: beat_cnt_next = 4'd7;
                    3'b110, 3'b111: beat_cnt_next = 4'd15;
                    default:        beat_cnt_next = 4'd0;
                endcase
            end else if ((HTRANS == TR_SEQ) && (beat_cnt_reg != 4'd0)) begin
                beat_cnt_next = beat_cnt_reg - 4'd1;
            end
        end

        if (split_set && hmastlock_reg) begin
            lock_split_next     = 1'b1;
            lock_split_idx_next = hmaster_reg;
        end
        if (!split_mask_calc[lock_split_idx_next])
            lock_split_next = 1'b0;

        if (!state_ok) begin
            hgrant_next         = DEF_GRANT;
            hmaster_next        = DEF_IDX;
            hmastlock_next      = 1'b0;
            beat_cnt_next       = 4'd0;
            split_mask_next     = 4'd0;
            lock_split_next     = 1'b0;
            lock_split_idx_next = 2'd0;
        end
    end

    // State registers with asynchronous reset to the default-master park.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hgrant_reg         <= DEF_GRANT;
            hmaster_reg        <= DEF_IDX;
            hmastlock_reg      <= 1'b0;
            beat_cnt_reg       <= 4'd0;
            split_mask_reg     <= 4'd0;
            lock_split_reg     <= 1'b0;
            lock_split_idx_reg <= 2'd0;
        end else begin
            hgrant_reg         <= hgrant_next;
            hmaster_reg        <= hmaster_next;
            hmastlock_reg      <= hmastlock_next;
            beat_cnt_reg       <= beat_cnt_next;
            split_mask_reg     <= split_mask_next;
            lock_split_reg     <= lock_split_next;
            lock_split_idx_reg <= lock_split_idx_next;
        end
    end

    assign HGRANT    = hgrant_reg;
    assign HMASTER   = hmaster_reg;
    assign HMASTLOCK = hmastlock_reg;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed testbench for ahb_arbiter: reset parking, priority, fixed bursts
// with wait states, SPLIT masking, locked SPLIT and mid-burst async reset.
module tb_ahb_arbiter;

    logic       HCLK;
    logic       HRESETn;
    logic [3:0] HBUSREQ;
    logic [3:0] HLOCK;
    logic [1:0] HTRANS;
    logic [2:0] HBURST;
    logic       HREADY;
    logic [1:0] HRESP;
    logic [3:0] HSPLIT;
    logic [3:0] HGRANT;
    logic [1:0] HMASTER;
    logic       HMASTLOCK;

    int checks = 0;
    int errors = 0;

    ahb_arbiter #(.DEFAULT_MASTER(1)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HBUSREQ   (HBUSREQ),
        .HLOCK     (HLOCK),
        .HTRANS    (HTRANS),
        .HBURST    (HBURST),
        .HREADY    (HREADY),
        .HRESP     (HRESP),
        .HSPLIT    (HSPLIT),
        .HGRANT    (HGRANT),
        .HMASTER   (HMASTER),
        .HMASTLOCK (HMASTLOCK)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
        $display("check %-14s observed %b expected %b", tag, obs, exp);
    endtask

    initial begin
        HRESETn = 1'b1;
        HBUSREQ = 4'b0000;
        HLOCK   = 4'b0000;
        HTRANS  = 2'b00;
        HBURST  = 3'b000;
        HREADY  = 1'b1;
        HRESP   = 2'b00;
        HSPLIT  = 4'b0000;

        // ---- Reset and idle parking on master 1
        #1 HRESETn = 1'b0;
        #1;
        check("rst_grant", HGRANT, 4'b0010);
        check("rst_master", {2'b00, HMASTER}, 4'd1);
        check("rst_lock", {3'b000, HMASTLOCK}, 4'd0);
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_grant", HGRANT, 4'b0010);
        end

        // ---- M2 and M3 request while M1 owns
        HBUSREQ = 4'b1100;
        step();
        check("req_grant2", HGRANT, 4'b0100);
        check("req_mst_old", {2'b00, HMASTER}, 4'd1);
        step();
        check("req_mst2", {2'b00, HMASTER}, 4'd2);
        HBUSREQ = 4'b1000;
        step();
        check("req_grant3", HGRANT, 4'b1000);

        // ---- Move to M2, then INCR4 with M1 requesting
        HBUSREQ = 4'b0100;
        step();
        check("b_grant2", HGRANT, 4'b0100);
        step();
        check("b_mst2", {2'b00, HMASTER}, 4'd2);
        HBUSREQ = 4'b0110;
        HTRANS  = 2'b10;
        HBURST  = 3'b011;
        step();
        check("b_nonseq", HGRANT, 4'b0100);
        check("b_cnt3", dut.beat_cnt_reg, 4'd3);
        HTRANS = 2'b11;
        step();
        check("b_beat2", HGRANT, 4'b0100);
        step();
        check("b_beat3", HGRANT, 4'b0100);
        step();
        check("b_beat4", HGRANT, 4'b0010);
        check("b_cnt0", dut.beat_cnt_reg, 4'd0);

        // ---- Same burst with two wait states on beat 2
        HTRANS  = 2'b00;
        HBUSREQ = 4'b0100;
        step();
        check("w_grant2", HGRANT, 4'b0100);
        step();
        check("w_mst2", {2'b00, HMASTER}, 4'd2);
        HBUSREQ = 4'b0110;
        HTRANS  = 2'b10;
        step();
        check("w_nonseq", HGRANT, 4'b0100);
        HTRANS = 2'b11;
        HREADY = 1'b0;
        step();
        check("w_wait1", HGRANT, 4'b0100);
        step();
        check("w_wait2", HGRANT, 4'b0100);
        check("w_cnt_held", dut.beat_cnt_reg, 4'd3);
        HREADY = 1'b1;
        step();
        check("w_beat2", HGRANT, 4'b0100);
        step();
        check("w_beat3", HGRANT, 4'b0100);
        step();
        check("w_beat4", HGRANT, 4'b0010);

        // ---- SPLIT on M1 with no other requester
        HTRANS  = 2'b00;
        HBURST  = 3'b000;
        HBUSREQ = 4'b0010;
        step();
        check("s_mst1", {2'b00, HMASTER}, 4'd1);
        HRESP  = 2'b11;
        HREADY = 1'b0;
        step();
        check("s_mask", dut.split_mask_reg, 4'b0010);
        check("s_frozen", HGRANT, 4'b0010);
        HREADY = 1'b1;
        step();
        check("s_grant0", HGRANT, 4'b0001);
        HRESP = 2'b00;
        step();
        check("s_park0", HGRANT, 4'b0001);
        check("s_mst0", {2'b00, HMASTER}, 4'd0);
        HSPLIT = 4'b0010;
        step();
        check("s_unmask", dut.split_mask_reg, 4'b0000);
        HSPLIT = 4'b0000;
        step();
        check("s_regrant1", HGRANT, 4'b0010);

        // ---- Locked M3 split while M1 and M2 request
        HBUSREQ = 4'b1000;
        HLOCK   = 4'b1000;
        step();
        check("l_grant3", HGRANT, 4'b1000);
        step();
        check("l_mst3", {2'b00, HMASTER}, 4'd3);
        check("l_mastlock", {3'b000, HMASTLOCK}, 4'd1);
        HBUSREQ = 4'b1110;
        step();
        check("l_hold3", HGRANT, 4'b1000);
        HRESP  = 2'b11;
        HREADY = 1'b0;
        step();
        check("l_mask", dut.split_mask_reg, 4'b1000);
        HREADY = 1'b1;
        step();
        check("l_grant0", HGRANT, 4'b0001);
        HRESP = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            check("l_park0", HGRANT, 4'b0001);
        end
        HSPLIT = 4'b1000;
        step();
        check("l_resume3", HGRANT, 4'b1000);
        check("l_unmask", dut.split_mask_reg, 4'b0000);
        HSPLIT = 4'b0000;
        step();
        check("l_keep3", HGRANT, 4'b1000);
        check("l_mst3b", {2'b00, HMASTER}, 4'd3);

        // ---- Async reset in beat 3 of an INCR8 by M2
        HLOCK   = 4'b0000;
        HBUSREQ = 4'b0100;
        step();
        check("r_grant2", HGRANT, 4'b0100);
        step();
        check("r_mst2", {2'b00, HMASTER}, 4'd2);
        HTRANS = 2'b10;
        HBURST = 3'b101;
        step();
        HTRANS = 2'b11;
        step();
        check("r_cnt6", dut.beat_cnt_reg, 4'd6);
        #2 HRESETn = 1'b0;
        #1;
        check("r_grant", HGRANT, 4'b0010);
        check("r_master", {2'b00, HMASTER}, 4'd1);
        check("r_lock", {3'b000, HMASTLOCK}, 4'd0);
        check("r_cnt0", dut.beat_cnt_reg, 4'd0);
        HRESETn = 1'b1;
        HTRANS  = 2'b00;
        HBURST  = 3'b000;
        HBUSREQ = 4'b1000;
        step();
        check("r_after3", HGRANT, 4'b1000);
        step();
        check("r_mst3", {2'b00, HMASTER}, 4'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
